rob_tag_ctrl: RTL and testbench

ROB_TAG_CTRL -- requirements
Module: rob_tag_ctrl

---
 rtl/rob_tag_ctrl.sv | 110 +++++++++++
 tb/tb_rob_tag_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_tag_ctrl.sv
// Tag issue/retire controller for a reorder buffer: hands out sequential tags,
// checks that retirements come back in order, and supports a drain handshake.
module rob_tag_ctrl #(
    parameter int TAG_W = 10,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic [TAG_W-1:0] req_tag_o,
    input  logic             ret_valid_i,
    input  logic             ret_ready_i,
    input  logic [15:0]      ret_rid_i,
    input  logic             drain_i,
    output logic             drained_o,
    output logic [10:0]      outstanding_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    localparam logic [10:0] DEPTH_C = 11'(DEPTH);

    state_t           state;
    logic [TAG_W-1:0] next_tag;
    logic [TAG_W-1:0] exp_tag;
    logic [10:0]      count;

    logic req_fire;
    logic ret_fire;
    logic ret_ok;
    logic rid_bad;

    // Only the low TAG_W bits of the ROB id carry the tag.
    logic unused_rid_hi;
    assign unused_rid_hi = ^ret_rid_i[15:TAG_W];

    assign req_ready_o   = (state == ST_RUN) && !drain_i && (count < DEPTH_C);
    assign req_tag_o     = next_tag;
    assign outstanding_o = count;

    assign req_fire = req_valid_i && req_ready_o;
    assign ret_fire = ret_valid_i && ret_ready_i;
    // A retire with nothing outstanding is an error and must not move the counters.
    assign ret_ok   = ret_fire && (count != 11'd0);
    assign rid_bad  = ret_ok && (ret_rid_i[TAG_W-1:0] != exp_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_tag <= '0;
            exp_tag  <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (req_fire) begin
                next_tag <= next_tag + TAG_W'(1);
            end
            if (ret_ok) begin
                exp_tag <= exp_tag + TAG_W'(1);
            end
            case ({req_fire, ret_ok})
                2'b10:   count <= count + 11'd1;
                2'b01:   count <= count - 11'd1;
                default: count <= count;
            endcase
            if (rid_bad || (ret_fire && (count == 11'd0))) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drained_o <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (drain_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_i) begin
                        state <= ST_RUN;
                    end else if ((count == 11'd0) && !req_fire) begin
                        state     <= ST_DRAINED;
                        drained_o <= 1'b1;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_i) begin
                        state     <= ST_RUN;
                        drained_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// Bench for rob_tag_ctrl: directed vector table, corner-case sequences, and a
// randomized run against a queue-based reference model.
module tb_rob_tag_ctrl;

    localparam int TAG_W = 10;
    localparam int DEPTH = 4;
    localparam int TAGS  = 1 << TAG_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [9:0]  req_tag_o;
    logic        ret_valid_i = 1'b0;
    logic        ret_ready_i = 1'b0;
    logic [15:0] ret_rid_i = '0;
    logic        drain_i = 1'b0;
    logic        drained_o;
    logic [10:0] outstanding_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    rob_tag_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_tag_o(req_tag_o),
        .ret_valid_i(ret_valid_i),
        .ret_ready_i(ret_ready_i),
        .ret_rid_i(ret_rid_i),
        .drain_i(drain_i),
        .drained_o(drained_o),
        .outstanding_o(outstanding_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rv; bit retv; bit retr; int rid; bit drain;
        bit e_ready; int e_tag; int e_cnt; bit e_err; bit e_dr;
    } vec_t;
    vec_t tbl[14];

    // Reference model: outstanding tags in issue order, plus the drain mode.
    int q[$];
    int m_tag;
    bit m_err;
    int m_mode; // 0 running, 1 draining, 2 drained

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        req_valid_i = 1'b0;
        ret_valid_i = 1'b0;
        ret_ready_i = 1'b0;
        ret_rid_i   = '0;
        drain_i     = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clr_inputs();
        settle();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_tag", req_tag_o, 0);
        chk("rst_cnt", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_drained", drained_o, 0);
        tick();
        rst_n = 1'b1;
        q.delete();
        m_tag  = 0;
        m_err  = 0;
        m_mode = 0;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid_i = 1'b1;
            tick();
        end
        req_valid_i = 1'b0;
    endtask

    task automatic retire(input int rid);
        ret_valid_i = 1'b1;
        ret_ready_i = 1'b1;
        ret_rid_i   = 16'(rid);
    endtask

    task automatic model_check();
        bit m_ready;
        m_ready = (m_mode == 0) && !drain_i && (q.size() < DEPTH);
        chk("rnd_ready", req_ready_o, int'(m_ready));
        chk("rnd_tag", req_tag_o, m_tag);
        chk("rnd_cnt", outstanding_o, q.size());
        chk("rnd_err", err_o, int'(m_err));
        chk("rnd_drained", drained_o, int'(m_mode == 2));
    endtask

    task automatic model_step();
        bit m_ready, rq, rt;
        int cnt_before;
        cnt_before = q.size();
        m_ready = (m_mode == 0) && !drain_i && (cnt_before < DEPTH);
        rq = req_valid_i && m_ready;
        rt = ret_valid_i && ret_ready_i;
        if (rt) begin
            if (q.size() == 0) m_err = 1;
            else begin
                if (int'(ret_rid_i[9:0]) != q[0]) m_err = 1;
                void'(q.pop_front());
            end
        end
        if (rq) begin
            q.push_back(m_tag);
            m_tag = (m_tag + 1) % TAGS;
        end
        case (m_mode)
            0: if (drain_i) m_mode = 1;
            1: if (!drain_i) m_mode = 0;
               else if (cnt_before == 0 && !rq) m_mode = 2;
            default: if (!drain_i) m_mode = 0;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        int base;

        //            rv retv retr rid drn  rdy tag cnt err dr
        tbl[0]  = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,  1, 1, 1, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0,  1, 2, 2, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0,  1, 3, 3, 0, 0};
        tbl[4]  = '{0, 1, 1, 1, 0,  1, 3, 2, 0, 0};
        tbl[5]  = '{0, 1, 1, 2, 0,  1, 3, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,  1, 3, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0,  1, 3, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0,  1, 4, 1, 0, 0};
        tbl[9]  = '{1, 1, 1, 3, 0,  1, 5, 2, 0, 0};
        tbl[10] = '{0, 1, 0, 9, 0,  1, 6, 2, 0, 0};
        tbl[11] = '{0, 1, 1, 4, 0,  1, 6, 2, 0, 0};
        tbl[12] = '{0, 1, 1, 5, 0,  1, 6, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0,  1, 6, 0, 0, 0};

        reset_dut();
        foreach (tbl[i]) begin
            req_valid_i = tbl[i].rv;
            ret_valid_i = tbl[i].retv;
            ret_ready_i = tbl[i].retr;
            ret_rid_i   = 16'(tbl[i].rid);
            drain_i     = tbl[i].drain;
            settle();
            chk($sformatf("vec%0d_ready", i), req_ready_o, int'(tbl[i].e_ready));
            chk($sformatf("vec%0d_tag", i), req_tag_o, tbl[i].e_tag);
            chk($sformatf("vec%0d_cnt", i), outstanding_o, tbl[i].e_cnt);
            chk($sformatf("vec%0d_err", i), err_o, int'(tbl[i].e_err));
            chk($sformatf("vec%0d_drained", i), drained_o, int'(tbl[i].e_dr));
            tick();
        end
        clr_inputs();

        // Full: ready drops at DEPTH and returns one cycle after a retire.
        reset_dut();
        issue(DEPTH);
        req_valid_i = 1'b1;
        retire(0);
        settle();
        chk("full_ready_same", req_ready_o, 0);
        chk("full_cnt", outstanding_o, DEPTH);
        tick();
        ret_valid_i = 1'b0;
        settle();
        chk("full_ready_next", req_ready_o, 1);
        chk("full_cnt_dec", outstanding_o, DEPTH - 1);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("full_refill", outstanding_o, DEPTH);
        chk("full_ready_again", req_ready_o, 0);

        // Out-of-order rid sets a sticky error.
        reset_dut();
        issue(1);
        retire(5);
        settle();
        chk("err_pre", err_o, 0);
        tick();
        clr_inputs();
        settle();
        chk("err_bad_rid", err_o, 1);
        chk("err_bad_rid_cnt", outstanding_o, 0);
        repeat (3) tick();
        settle();
        chk("err_sticky", err_o, 1);

        // Retire with nothing outstanding.
        reset_dut();
        retire(0);
        tick();
        clr_inputs();
        settle();
        chk("err_empty", err_o, 1);
        chk("err_empty_cnt", outstanding_o, 0);

        // Drain from empty: drained two edges after drain_i.
        reset_dut();
        drain_i = 1'b1;
        settle();
        chk("drn0_ready", req_ready_o, 0);
        tick();
        settle();
        chk("drn0_drained_1", drained_o, 0);
        tick();
        settle();
        chk("drn0_drained_2", drained_o, 1);
        tick();
        drain_i = 1'b0;
        settle();
        chk("drn0_ready_in_drained", req_ready_o, 0);
        tick();
        settle();
        chk("drn0_ready_back", req_ready_o, 1);
        chk("drn0_drained_off", drained_o, 0);

        // Drain with two outstanding tags.
        reset_dut();
        issue(2);
        drain_i = 1'b1;
        settle();
        chk("drn2_ready", req_ready_o, 0);
        tick();
        retire(0);
        settle();
        chk("drn2_cnt", outstanding_o, 2);
        tick();
        retire(1);
        tick();
        ret_valid_i = 1'b0;
        settle();
        chk("drn2_cnt0", outstanding_o, 0);
        chk("drn2_not_yet", drained_o, 0);
        tick();
        settle();
        chk("drn2_drained", drained_o, 1);
        tick();
        drain_i = 1'b0;
        tick();
        settle();
        chk("drn2_ready_back", req_ready_o, 1);
        chk("drn2_drained_off", drained_o, 0);
        chk("drn2_err", err_o, 0);

        // Wrap-around through all tags.
        reset_dut();
        for (int i = 0; i <= TAGS; i++) begin
            req_valid_i = 1'b1;
            settle();
            chk("wrap_tag", req_tag_o, i % TAGS);
            tick();
            req_valid_i = 1'b0;
            retire(i % TAGS);
            tick();
            ret_valid_i = 1'b0;
        end
        settle();
        chk("wrap_err", err_o, 0);
        chk("wrap_cnt", outstanding_o, 0);

        // Asynchronous reset with tags outstanding.
        tick();
        issue(3);
        settle();
        chk("mid_cnt", outstanding_o, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", outstanding_o, 0);
        chk("mid_rst_tag", req_tag_o, 0);
        chk("mid_rst_ready", req_ready_o, 1);
        tick();
        rst_n = 1'b1;
        req_valid_i = 1'b1;
        settle();
        chk("mid_first_tag", req_tag_o, 0);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("mid_cnt_after", outstanding_o, 1);
        tick();

        // Randomized run against the reference model.
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                reset_dut();
                continue;
            end
            req_valid_i = 1'($urandom);
            if ($urandom_range(15) == 0) drain_i = ~drain_i;
            if (q.size() > 0) ret_valid_i = 1'($urandom);
            else ret_valid_i = ($urandom_range(39) == 0);
            ret_ready_i = ($urandom_range(3) != 0);
            base = (q.size() > 0) ? q[0] : m_tag;
            r = {6'($urandom), 10'(base)};
            if ($urandom_range(49) == 0) r[9:0] = r[9:0] ^ 10'(1 << $urandom_range(9));
            ret_rid_i = r;
            settle();
            model_check();
            model_step();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
